single_port_ram_bist: RTL and testbench
=======================================

# single_port_ram_bist

Built-in self-test engine that acts as the initiator on a single-port RAM interface (`data`/`addr`/`we`/`q`). It runs a fixed March test over every address and reports pass/fail with the first failing location. It sits beside the RAM behind a mux owned by the integrating level; while `busy` is high it owns the RAM port.

## Interface
- `ADDR_WIDTH`, default 6: RAM address width. The test covers N = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 8: RAM word width.
- `PATTERN`, default 8'h55: background pattern P. Its complement ~P is the second background.

Ports:
- `clk`, in, 1: clock; everything on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level, sampled only in IDLE.
- `busy`, out, 1: test in progress; the engine owns the RAM port.
- `done`, out, 1: single-cycle pulse at the end of a test.
- `pass`, out, 1: result of the last test. Sticky until the next start.
- `fail_addr`, out, ADDR_WIDTH: address of the first miscompare.
- `fail_expected`, out, DATA_WIDTH: expected word at the first miscompare.
- `fail_actual`, out, DATA_WIDTH: read word at the first miscompare.
- `ram_data`, out, DATA_WIDTH: write data to the RAM.
- `ram_addr`, out, ADDR_WIDTH: RAM address.
- `ram_we`, out, 1: RAM write enable.
- `ram_q`, in, DATA_WIDTH: RAM read data. One-cycle read latency.

## Operation
- States: IDLE, M0, M1, M2, M3, CHK, DONE.
- March sequence:
  - M0: ascending, write P.
  - M1: ascending, per address read (expect P) then write ~P.
  - M2: descending, per address read (expect ~P) then write P.
  - M3: ascending, read (expect P).
  - CHK: one extra cycle to compare the final M3 read.
- Each M1/M2 address takes 2 cycles: a read cycle (`ram_we`=0), then a write cycle with the same `ram_addr` and `ram_we`=1.
- Read compare:
  - `ram_q` is compared at the edge ending the cycle after the read cycle.
  - A pipeline register carries the expected word and address.
  - In M1/M2 the compare overlaps that address's write cycle.
- Address counter is ADDR_WIDTH bits.
  - Ascending elements run 0..N-1.
  - M2 runs N-1..0.
  - The element advances on counter terminal value. There is no wrap beyond one pass.
- Miscompare:
  - At that edge, capture `fail_addr`, `fail_expected` and `fail_actual`.
  - Clear `pass`, go to DONE and abort the remaining elements.
  - Only the first miscompare is recorded.
- Success: CHK compare is clean, so `pass`=1 and go to DONE.
- DONE lasts exactly one cycle (`done`=1), then IDLE.
- IDLE, CHK and DONE drive `ram_we`=0, `ram_addr`=0, `ram_data`=0.
- `start` while busy is ignored.
- If `start` is held high, a new test begins on the first IDLE cycle after DONE.
- On a new start, clear `pass` and `fail_*`.

## Timing
- Reset (async, immediate) sets state IDLE and all outputs 0: `busy`, `done`, `pass`, `fail_*`, `ram_*`. An in-flight test is aborted and RAM contents are undefined.
- Edge E0 samples `start`=1 in IDLE.
  - `busy` rises at E0.
  - First M0 write occurs in cycle 0 (E0 to E1) with `ram_addr`=0, `ram_data`=P and `ram_we`=1.
- Cycle map for a clean run, with N=64:
  - M0: cycles 0..N-1 (0..63).
  - M1: cycles N..3N-1 (64..191).
  - M2: cycles 3N..5N-1 (192..319).
  - M3: cycles 5N..6N-1 (320..383).
  - CHK: cycle 6N (384).
- Clean run: at edge E(6N+1) = E385, `done`=1, `busy`=0 and `pass`=1 for one cycle, then `done`=0.
- Failing run: `busy` falls and `done` rises at the edge that detects the miscompare.
- The first M1 read at address a is compared at the edge ending the following write cycle, i.e. E(N+2a+2).

## Test plan
- Fault-free RAM model, N=64, start pulse at E0:
  - `ram_we`=1 for cycles 0..63 with data 0x55.
  - `done` pulses at E385 with `pass`=1.
  - Final memory is all 0x55.
- Stuck-at-1 on bit 0 of address 5 in the bench model:
  - M1 passes.
  - M2 miscompare gives `fail_addr`=5, `fail_expected`=0xAA, `fail_actual`=0xAB and `pass`=0.
  - `done` pulses right after the compare, well before E385.
- Address-alias fault (bench aliases address 6 onto 2): first miscompare reports `fail_addr`=2 or 6 with `pass`=0, and no further `fail_*` updates.
- `rst_n` low during cycle 100 (M1):
  - `busy`, `ram_we` and `ram_addr` go to 0 without a clock edge.
  - After release, a new start completes with `pass`=1 at E385.
- `start` pulsed again at cycle 50: ignored, and the sequence and `done` timing are unchanged.
- `start` held high continuously: `done` at E385, one IDLE cycle, then a second run whose `busy` rises one edge later.
  - `pass` clears at the restart.
  - `pass` reasserts at the second `done`.

Source files
------------

// File: rtl/single_port_ram_bist.sv
// March BIST initiator for a single-port RAM with one-cycle read latency; 6N+1 cycles per clean run.
// No backpressure: owns the RAM port while busy; start is sampled only in IDLE.
module single_port_ram_bist #(
    parameter int unsigned            ADDR_WIDTH = 6,
    parameter int unsigned            DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]  PATTERN    = DATA_WIDTH'(8'h55)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [2:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_CHK, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [DATA_WIDTH-1:0] PAT      = PATTERN;
    localparam logic [DATA_WIDTH-1:0] PAT_N    = ~PATTERN;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  we_q;
    logic                  wr_ph_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_exp_q;
    logic [DATA_WIDTH-1:0] fail_act_q;
    logic                  cmp_vld_q;
    logic [DATA_WIDTH-1:0] cmp_exp_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;
    logic                  mis;

    // cmp_vld_q marks the cycle in which ram_q returns the word read one cycle earlier.
    assign mis = cmp_vld_q && (ram_q != cmp_exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            wr_ph_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            cmp_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_M0;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_exp_q  <= '0;
                        fail_act_q  <= '0;
                        addr_q      <= '0;
                        we_q        <= 1'b1;
                        data_q      <= PAT;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: begin
                    if (mis) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_addr_q <= cmp_addr_q;
                        fail_exp_q  <= cmp_exp_q;
                        fail_act_q  <= ram_q;
                        addr_q      <= '0;
                        we_q        <= 1'b0;
                        data_q      <= '0;
                        wr_ph_q     <= 1'b0;
                    end else begin
                        case (state_q)
                            S_M0: begin
                                if (addr_q == ADDR_MAX) begin
                                    state_q <= S_M1;
                                    addr_q  <= '0;
                                    we_q    <= 1'b0;
                                    data_q  <= '0;
                                    wr_ph_q <= 1'b0;
                                end else begin
                                    addr_q <= addr_q + 1'b1;
                                end
                            end
                            S_M1, S_M2: begin
                                if (!wr_ph_q) begin
                                    cmp_vld_q  <= 1'b1;
                                    cmp_exp_q  <= (state_q == S_M1) ? PAT : PAT_N;
                                    cmp_addr_q <= addr_q;
                                    wr_ph_q    <= 1'b1;
                                    we_q       <= 1'b1;
                                    data_q     <= (state_q == S_M1) ? PAT_N : PAT;
                                end else begin
                                    wr_ph_q <= 1'b0;
                                    we_q    <= 1'b0;
                                    data_q  <= '0;
                                    if (state_q == S_M1) begin
                                        if (addr_q == ADDR_MAX) begin
                                            state_q <= S_M2;
                                        end else begin
                                            addr_q <= addr_q + 1'b1;
                                        end
                                    end else if (addr_q == '0) begin
                                        state_q <= S_M3;
                                    end else begin
                                        addr_q <= addr_q - 1'b1;
                                    end
                                end
                            end
                            S_M3: begin
                                cmp_vld_q  <= 1'b1;
                                cmp_exp_q  <= PAT;
                                cmp_addr_q <= addr_q;
                                if (addr_q == ADDR_MAX) begin
                                    state_q <= S_CHK;
                                    addr_q  <= '0;
                                end else begin
                                    addr_q <= addr_q + 1'b1;
                                end
                            end
                            S_CHK: begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_addr     = fail_addr_q;
    assign fail_expected = fail_exp_q;
    assign fail_actual   = fail_act_q;
    assign ram_data      = data_q;
    assign ram_addr      = addr_q;
    assign ram_we        = we_q;

endmodule

// File: tb/tb_single_port_ram_bist.sv
// Bench for single_port_ram_bist: RAM model with selectable faults, vector table plus reset/restart sequences.
module tb_single_port_ram_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass, ram_we;
    logic [5:0] fail_addr, ram_addr;
    logic [7:0] fail_expected, fail_actual, ram_data;
    logic [7:0] ram_q = 8'h00;

    logic [7:0] mem [64];
    int         fault_mode = 0;   // 0 clean, 1 stuck-at-1 bit0 @5, 2 alias 6 -> 2
    int         pass_cnt = 0;
    int         total = 0;

    always #5 clk = ~clk;

    single_port_ram_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_addr(fail_addr), .fail_expected(fail_expected),
        .fail_actual(fail_actual), .ram_data(ram_data), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    function automatic logic [5:0] phys(input logic [5:0] a);
        return (fault_mode == 2 && a == 6'd6) ? 6'd2 : a;
    endfunction

    always @(posedge clk) begin
        logic [7:0] v;
        v = mem[phys(ram_addr)];
        if (fault_mode == 1 && ram_addr == 6'd5) v[0] = 1'b1;
        ram_q <= v;
        if (ram_we) mem[phys(ram_addr)] <= ram_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        int         mode;
        bit         pulse50;
        bit         hold;
        int         done_cyc;
        bit         exp_pass;
        logic [5:0] f_addr;
        logic [7:0] f_exp;
        logic [7:0] f_act;
    } vec_t;

    vec_t vecs [5];

    // Starts a run (E0 = first edge after entry) and checks it; returns one cycle after done.
    task automatic run_vec(input vec_t v, input string nm);
        int   c;
        int   m0_bad;
        bit   got;
        logic [5:0] fa;
        fault_mode = v.mode;
        start = 1'b1;
        @(posedge clk); #1;
        if (!v.hold) start = 1'b0;
        c = 0; m0_bad = 0; got = 0;
        while (c < 500 && !got) begin
            if (c < 64 && (ram_we !== 1'b1 || ram_addr !== 6'(c) || ram_data !== 8'h55)) m0_bad++;
            if (c == 64 && ram_we !== 1'b0) m0_bad++;
            if (v.pulse50 && c == 50) start = 1'b1;
            if (v.pulse50 && c == 51) start = 1'b0;
            if (done === 1'b1) got = 1;
            else begin
                @(posedge clk); #1;
                c++;
            end
        end
        chk({nm, " done_cycle"}, c, v.done_cyc);
        chk({nm, " m0_writes"}, m0_bad, 0);
        chk({nm, " pass"}, pass, v.exp_pass);
        chk({nm, " busy_at_done"}, busy, 0);
        chk({nm, " fail_addr"}, fail_addr, v.f_addr);
        chk({nm, " fail_expected"}, fail_expected, v.f_exp);
        chk({nm, " fail_actual"}, fail_actual, v.f_act);
        fa = fail_addr;
        @(posedge clk); #1;
        chk({nm, " done_one_cycle"}, done, 0);
        if (v.mode == 0) begin
            int bad = 0;
            for (int i = 0; i < 64; i++) if (mem[i] !== 8'h55) bad++;
            chk({nm, " final_mem"}, bad, 0);
        end else begin
            repeat (4) @(posedge clk);
            #1;
            chk({nm, " fail_addr_stable"}, fail_addr, fa);
            chk({nm, " pass_sticky"}, pass, 0);
        end
    endtask

    initial begin
        int c;
        vecs[0] = '{0, 1'b0, 1'b0, 385, 1'b1, 6'd0, 8'h00, 8'h00};
        vecs[1] = '{1, 1'b0, 1'b0, 310, 1'b0, 6'd5, 8'hAA, 8'hAB};
        vecs[2] = '{2, 1'b0, 1'b0,  78, 1'b0, 6'd6, 8'h55, 8'hAA};
        vecs[3] = '{0, 1'b1, 1'b0, 385, 1'b1, 6'd0, 8'h00, 8'h00};
        vecs[4] = '{0, 1'b0, 1'b1, 385, 1'b1, 6'd0, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst ram_we", ram_we, 0);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_data", ram_data, 0);
        chk("rst fail_addr", fail_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of M1 (cycle 100, address 18 read).
        fault_mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("midrun busy_before", busy, 1);
        chk("midrun addr_before", ram_addr, 18);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun busy_async", busy, 0);
        chk("midrun we_async", ram_we, 0);
        chk("midrun addr_async", ram_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0], "after_reset");

        // start held high: second run begins after exactly one IDLE cycle.
        run_vec(vecs[4], "hold1");
        chk("hold idle_busy", busy, 0);
        @(posedge clk); #1;
        chk("hold busy_restart", busy, 1);
        chk("hold pass_cleared", pass, 0);
        c = 0;
        while (c < 500 && done !== 1'b1) begin
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        chk("hold2 done_cycle", c, 385);
        chk("hold2 pass", pass, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
